// File: rtl/cache_mem_responder.sv
// Memory-side responder for the data-cache miss path.
// Services block reads/writes from a backing array after a fixed latency.
module cache_mem_responder #(
    parameter int ADDR_WIDTH  = 64,
    parameter int BLOCK_WIDTH = 128,
    parameter int DEPTH       = 1024,
    parameter int RD_LATENCY  = 4,
    parameter int WR_LATENCY  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_rden,
    input  logic                   mem_wren,
    input  logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic [BLOCK_WIDTH-1:0] mem_wdata,
    output logic [BLOCK_WIDTH-1:0] mem_rdata,
    output logic                   mem_ready,
    output logic                   mem_busy
);

    localparam int OFS    = $clog2(BLOCK_WIDTH / 8);
    localparam int IW     = $clog2(DEPTH);
    localparam int MAXLAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int CW     = $clog2(MAXLAT + 1);

    localparam logic [CW-1:0] RD_INIT = CW'(RD_LATENCY - 1);
    localparam logic [CW-1:0] WR_INIT = CW'(WR_LATENCY - 1);

    if (RD_LATENCY < 1 || WR_LATENCY < 1) begin : g_bad_latency
        $error("cache_mem_responder: latencies must be >= 1");
    end
    if ((BLOCK_WIDTH % 8) != 0) begin : g_bad_width
        $error("cache_mem_responder: BLOCK_WIDTH must be a multiple of 8");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("cache_mem_responder: DEPTH must be a power of 2");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   op_wr_q, op_wr_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [BLOCK_WIDTH-1:0] wdata_q, wdata_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BLOCK_WIDTH-1:0] rdata_q, rdata_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   mem_we;

    logic [BLOCK_WIDTH-1:0] mem_arr [DEPTH];

    // Offset and upper address bits are intentionally ignored.
    logic unused_addr;
    assign unused_addr = ^mem_addr;

    // Next-state, request capture and access scheduling.
    always_comb begin
        state_d = state_q;
        op_wr_d = op_wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (mem_wren) begin
                    op_wr_d = 1'b1;
                    idx_d   = mem_addr[OFS +: IW];
                    wdata_d = mem_wdata;
                    cnt_d   = WR_INIT;
                    state_d = S_BUSY;
                end else if (mem_rden) begin
                    op_wr_d = 1'b0;
                    idx_d   = mem_addr[OFS +: IW];
                    cnt_d   = RD_INIT;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = S_DONE;
                    if (op_wr_q) begin
                        mem_we = 1'b1;
                    end else begin
                        rdata_d = mem_arr[idx_q];
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        ready_d = (state_d == S_DONE);
        busy_d  = (state_d != S_IDLE);
    end

    // Control state and registered outputs; reset drops any in-flight op.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            op_wr_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_wr_q <= op_wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    // Backing array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_arr[idx_q] <= wdata_q;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = ready_q;
    assign mem_busy  = busy_q;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Bench for cache_mem_responder: vector table, corner sequences,
// latency sweep instances and randomized traffic against a model.
module tb_cache_mem_responder;

    logic         clk;
    logic         rst;
    logic         mem_rden;
    logic         mem_wren;
    logic [63:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
    logic         mem_busy;
    logic [127:0] u1_rdata;
    logic         u1_ready;
    logic         u1_busy;
    logic [127:0] u7_rdata;
    logic         u7_ready;
    logic         u7_busy;

    int n_vec = 0;
    int n_err = 0;

    cache_mem_responder dut (
        .clk(clk), .rst(rst),
        .mem_rden(mem_rden), .mem_wren(mem_wren),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_busy(mem_busy)
    );

    cache_mem_responder #(.RD_LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst),
        .mem_rden(mem_rden), .mem_wren(mem_wren),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(u1_rdata), .mem_ready(u1_ready), .mem_busy(u1_busy)
    );

    cache_mem_responder #(.RD_LATENCY(7)) u_lat7 (
        .clk(clk), .rst(rst),
        .mem_rden(mem_rden), .mem_wren(mem_wren),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(u7_rdata), .mem_ready(u7_ready), .mem_busy(u7_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit           wr;
        logic [63:0]  addr;
        logic [127:0] wdata;
        bit           chk;
        logic [127:0] exp;
    } vec_t;

    localparam int LAT = 4;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Counts edges until mem_ready, bounded; busy must hold meanwhile.
    task automatic wait_ready(output int n, output int busy_lo);
        n = 0;
        busy_lo = 0;
        while (!mem_ready && n < 40) begin
            if (!mem_busy) busy_lo++;
            @(posedge clk); #1;
            n++;
        end
        if (!mem_busy) busy_lo++;
    endtask

    // One full transaction from IDLE back to IDLE.
    task automatic txn(input bit wr, input bit rd, input logic [63:0] a,
                       input logic [127:0] d, output logic [127:0] q,
                       output int lat);
        int blo;
        mem_wren  = wr;
        mem_rden  = rd;
        mem_addr  = a;
        mem_wdata = d;
        @(posedge clk); #1;
        wait_ready(lat, blo);
        q = mem_rdata;
        mem_wren = 1'b0;
        mem_rden = 1'b0;
        chk("busy_during_txn", 128'(blo), 128'd0);
        @(posedge clk); #1;
        chk("ready_single_pulse", 128'(mem_ready), 128'd0);
    endtask

    localparam logic [127:0] D0 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0;
    localparam logic [127:0] D1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] D2 = 128'hA5A5_A5A5_0000_FFFF_1234_5678_9ABC_DEF0;
    localparam logic [127:0] DA = 128'hAAAA_0000_BBBB_1111_CCCC_2222_DDDD_3333;
    localparam logic [127:0] DB = 128'hB0B0_B0B0_B0B0_B0B0_B0B0_B0B0_B0B0_B0B0;
    localparam logic [127:0] DC = 128'hC0DE_C0DE_C0DE_C0DE_C0DE_C0DE_C0DE_C0DE;
    localparam logic [127:0] DO = 128'h0123_0123_0123_0123_0123_0123_0123_0123;
    localparam logic [127:0] DN = 128'hFEED_FEED_FEED_FEED_FEED_FEED_FEED_FEED;

    logic [127:0] model [int];

    initial begin
        vec_t         tbl [7];
        logic [127:0] q;
        logic [127:0] last_rd;
        bit           last_known;
        int           l, blo;
        int           r1, r7, c1, c7, b1lo, b7lo, b7tail;
        int           stray;

        tbl[0] = '{1'b1, 64'h40,                  D0, 1'b0, 128'd0};
        tbl[1] = '{1'b0, 64'h40,                  '0, 1'b1, D0};
        tbl[2] = '{1'b1, 64'h4040,                D1, 1'b0, 128'd0};
        tbl[3] = '{1'b0, 64'h4F,                  '0, 1'b1, D1};
        tbl[4] = '{1'b1, 64'h3FF0,                D2, 1'b0, 128'd0};
        tbl[5] = '{1'b0, 64'hFFFF_0000_0000_3FF0, '0, 1'b1, D2};
        tbl[6] = '{1'b0, 64'h0000_0001_0000_004C, '0, 1'b1, D1};

        rst = 1'b0;
        mem_rden = 1'b0;
        mem_wren = 1'b0;
        mem_addr = '0;
        mem_wdata = '0;
        #1;
        chk("reset_ready", 128'(mem_ready), 128'd0);
        chk("reset_busy",  128'(mem_busy),  128'd0);
        chk("reset_rdata", mem_rdata,       128'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // Latency sweep across the three instances with one shared read.
        mem_rden = 1'b1;
        mem_addr = 64'h0;
        @(posedge clk); #1;
        mem_rden = 1'b0;
        r1 = -1; r7 = -1; c1 = 0; c7 = 0; b1lo = 0; b7lo = 0; b7tail = 0;
        for (int c = 0; c < 12; c++) begin
            if (u1_ready) begin c1++; if (r1 < 0) r1 = c; end
            if (u7_ready) begin c7++; if (r7 < 0) r7 = c; end
            if (c <= 1 && !u1_busy) b1lo++;
            if (c <= 7 && !u7_busy) b7lo++;
            if (c >= 8 && u7_busy) b7tail++;
            @(posedge clk); #1;
        end
        chk("lat1_ready_cycle", 128'(r1), 128'd1);
        chk("lat1_ready_count", 128'(c1), 128'd1);
        chk("lat1_busy",        128'(b1lo), 128'd0);
        chk("lat7_ready_cycle", 128'(r7), 128'd7);
        chk("lat7_ready_count", 128'(c7), 128'd1);
        chk("lat7_busy",        128'(b7lo), 128'd0);
        chk("lat7_busy_tail",   128'(b7tail), 128'd0);

        // Table-driven vectors.
        for (int i = 0; i < 7; i++) begin
            txn(tbl[i].wr, !tbl[i].wr, tbl[i].addr, tbl[i].wdata, q, l);
            chk($sformatf("vec%0d_latency", i), 128'(l), 128'(LAT));
            if (tbl[i].chk) chk($sformatf("vec%0d_rdata", i), q, tbl[i].exp);
        end

        // Write-back then allocate with a back-to-back read.
        txn(1'b1, 1'b0, 64'h200, DB, q, l);
        mem_wren  = 1'b1;
        mem_addr  = 64'h100;
        mem_wdata = DC;
        @(posedge clk); #1;
        wait_ready(l, blo);
        chk("wb_latency", 128'(l), 128'(LAT));
        mem_wren = 1'b0;
        mem_rden = 1'b1;
        mem_addr = 64'h200;
        @(posedge clk); #1;
        chk("wb_done_pulse", 128'(mem_ready), 128'd0);
        wait_ready(l, blo);
        chk("alloc_gap", 128'(l + 1), 128'(LAT + 2));
        chk("alloc_rdata", mem_rdata, DB);
        mem_rden = 1'b0;
        @(posedge clk); #1;
        txn(1'b0, 1'b1, 64'h100, '0, q, l);
        chk("wb_committed", q, DC);

        // Simultaneous read and write: write first, then the held read.
        mem_wren  = 1'b1;
        mem_rden  = 1'b1;
        mem_addr  = 64'h80;
        mem_wdata = DA;
        @(posedge clk); #1;
        wait_ready(l, blo);
        chk("both_wr_latency", 128'(l), 128'(LAT));
        chk("both_wr_keeps_rdata", mem_rdata, DC);
        mem_wren = 1'b0;
        @(posedge clk); #1;
        wait_ready(l, blo);
        chk("both_rd_gap", 128'(l + 1), 128'(LAT + 2));
        chk("both_rd_rdata", mem_rdata, DA);
        mem_rden = 1'b0;
        @(posedge clk); #1;

        // Abort a write mid-flight with an asynchronous reset.
        txn(1'b1, 1'b0, 64'h300, DO, q, l);
        txn(1'b0, 1'b1, 64'h300, '0, q, l);
        chk("abort_pre_rdata", q, DO);
        mem_wren  = 1'b1;
        mem_addr  = 64'h300;
        mem_wdata = DN;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        #1;
        chk("async_rst_ready", 128'(mem_ready), 128'd0);
        chk("async_rst_busy",  128'(mem_busy),  128'd0);
        chk("async_rst_rdata", mem_rdata,       128'd0);
        mem_wren = 1'b0;
        stray = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (mem_ready || mem_busy) stray++;
        end
        rst = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            if (mem_ready || mem_busy) stray++;
        end
        chk("abort_no_stray", 128'(stray), 128'd0);
        txn(1'b0, 1'b1, 64'h300, '0, q, l);
        chk("abort_old_data", q, DO);

        // Randomized traffic against the associative-array model.
        last_known = 1'b1;
        last_rd = DO;
        for (int i = 0; i < 150; i++) begin
            logic [63:0]  a;
            logic [127:0] d;
            int           op, k;
            bit           w, r;
            a = {$urandom(), $urandom()};
            a[13:4] = 10'($urandom_range(0, 15));
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            op = int'($urandom_range(0, 3));
            w = (op == 0 || op == 1 || op == 3);
            r = (op >= 2);
            k = int'((a / 64'd16) % 64'd1024);
            txn(w, r, a, d, q, l);
            chk($sformatf("rnd%0d_latency", i), 128'(l), 128'(LAT));
            if (w) begin
                if (last_known) chk($sformatf("rnd%0d_wr_rdata", i), q, last_rd);
                model[k] = d;
            end else if (model.exists(k)) begin
                chk($sformatf("rnd%0d_rd_rdata", i), q, model[k]);
                last_rd = model[k];
                last_known = 1'b1;
            end else begin
                last_known = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
